// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequences one AES block encryption through the datapath.
// A Moore FSM walks LOAD -> KEY/ARK -> (SB_GO, SB_WAIT, SR, [MC], KEY, ARK)*
// -> DONE. It handshakes with the key schedule (rk_req/rk_ack) and with the
// multi-cycle sub_bytes unit (sb_start/sb_done). A stalled sub_bytes unit
// raises a sticky error flag after TIMEOUT wait cycles.
module aes_round_ctrl #(
    parameter int NR      = 10,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       abort_i,
    output logic       load_o,
    output logic       rk_req_o,
    output logic [3:0] rk_idx_o,
    input  logic       rk_ack_i,
    output logic       ark_en_o,
    output logic       sb_start_o,
    input  logic       sb_done_i,
    output logic       sr_en_o,
    output logic       mc_en_o,
    output logic [3:0] round_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    localparam logic [3:0] LP_NR       = 4'(NR);
    // Last value the wait counter reaches; sb_done_i may still win on it.
    localparam logic [7:0] LP_TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_KEY,
        S_ARK,
        S_SB_GO,
        S_SB_WAIT,
        S_SR,
        S_MC,
        S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_round;
    logic [3:0] w_round_nxt;
    logic       r_err;
    logic       w_err_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;

    // State, round index, error flag and wait counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_round <= 4'd0;
            r_err   <= 1'b0;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_round <= w_round_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; abort leaves round and error untouched.
    always_comb begin
        w_state_nxt = r_state;
        w_round_nxt = r_round;
        w_err_nxt   = r_err;
        w_cnt_nxt   = r_cnt;
        if (abort_i && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i && !abort_i) begin
                        w_state_nxt = S_LOAD;
                        w_round_nxt = 4'd0;
                        w_err_nxt   = 1'b0;
                    end
                end
                S_LOAD: w_state_nxt = S_KEY;
                S_KEY: begin
                    if (rk_ack_i) begin
                        w_state_nxt = S_ARK;
                    end
                end
                S_ARK: begin
                    if (r_round == LP_NR) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_round_nxt = r_round + 4'd1;
                        w_state_nxt = S_SB_GO;
                    end
                end
                S_SB_GO: begin
                    w_state_nxt = S_SB_WAIT;
                    w_cnt_nxt   = 8'd0;
                end
                S_SB_WAIT: begin
                    if (sb_done_i) begin
                        w_state_nxt = S_SR;
                    end else if (r_cnt == LP_TMO_LAST) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                S_SR: begin
                    // The final round skips MixColumns.
                    if (r_round < LP_NR) begin
                        w_state_nxt = S_MC;
                    end else begin
                        w_state_nxt = S_KEY;
                    end
                end
                S_MC:    w_state_nxt = S_KEY;
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Moore strobes decoded from the registered state.
    always_comb begin
        load_o     = 1'b0;
        rk_req_o   = 1'b0;
        ark_en_o   = 1'b0;
        sb_start_o = 1'b0;
        sr_en_o    = 1'b0;
        mc_en_o    = 1'b0;
        done_o     = 1'b0;
        case (r_state)
            S_LOAD:  load_o     = 1'b1;
            S_KEY:   rk_req_o   = 1'b1;
            S_ARK:   ark_en_o   = 1'b1;
            S_SB_GO: sb_start_o = 1'b1;
            S_SR:    sr_en_o    = 1'b1;
            S_MC:    mc_en_o    = 1'b1;
            S_DONE:  done_o     = 1'b1;
            default: begin
            end
        endcase
    end

    assign busy_o   = (r_state != S_IDLE);
    assign rk_idx_o = r_round;
    assign round_o  = r_round;
    assign err_o    = r_err;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl: dut0 runs NR=10/TIMEOUT=255, dut1 runs
// NR=1/TIMEOUT=3. Expected strobe events (kind, index, cycle offset from the
// accepted start, err flag) are queued when a run is launched; a monitor pops
// and compares each event the DUTs present. Responders emulate the key
// schedule and sub_bytes unit with programmable latencies.
module tb_aes_round_ctrl;

    localparam int K_LOAD = 0;
    localparam int K_KEY  = 1;
    localparam int K_ARK  = 2;
    localparam int K_SBGO = 3;
    localparam int K_SR   = 4;
    localparam int K_MC   = 5;
    localparam int K_DONE = 6;
    localparam int K_NONE = 7;

    typedef struct {
        int d;
        int kind;
        int idx;
        int t;
        int err;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       start_i    [2];
    logic       abort_i    [2];
    logic       rk_ack_i   [2];
    logic       sb_done_i  [2];
    logic       load_o     [2];
    logic       rk_req_o   [2];
    logic [3:0] rk_idx_o   [2];
    logic       ark_en_o   [2];
    logic       sb_start_o [2];
    logic       sr_en_o    [2];
    logic       mc_en_o    [2];
    logic [3:0] round_o    [2];
    logic       busy_o     [2];
    logic       done_o     [2];
    logic       err_o      [2];

    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  t0 [2];
    int  ack_lat [2];
    int  sb_lat [2];
    int  hang_round [2];
    bit  ack_hold [2];
    int  key_cnt [2];
    int  sb_cnt [2];
    bit  waiting [2];
    int  c_load [2];
    int  c_ark [2];
    int  c_sb [2];
    int  c_sr [2];
    int  c_mc [2];
    int  c_done [2];
    int  last_done_t [2];

    aes_round_ctrl #(.NR(10), .TIMEOUT(255)) u_dut0 (
        .clk(clk), .rst(rst), .start_i(start_i[0]), .abort_i(abort_i[0]),
        .load_o(load_o[0]), .rk_req_o(rk_req_o[0]), .rk_idx_o(rk_idx_o[0]),
        .rk_ack_i(rk_ack_i[0]), .ark_en_o(ark_en_o[0]), .sb_start_o(sb_start_o[0]),
        .sb_done_i(sb_done_i[0]), .sr_en_o(sr_en_o[0]), .mc_en_o(mc_en_o[0]),
        .round_o(round_o[0]), .busy_o(busy_o[0]), .done_o(done_o[0]), .err_o(err_o[0])
    );

    aes_round_ctrl #(.NR(1), .TIMEOUT(3)) u_dut1 (
        .clk(clk), .rst(rst), .start_i(start_i[1]), .abort_i(abort_i[1]),
        .load_o(load_o[1]), .rk_req_o(rk_req_o[1]), .rk_idx_o(rk_idx_o[1]),
        .rk_ack_i(rk_ack_i[1]), .ark_en_o(ark_en_o[1]), .sb_start_o(sb_start_o[1]),
        .sb_done_i(sb_done_i[1]), .sr_en_o(sr_en_o[1]), .mc_en_o(mc_en_o[1]),
        .round_o(round_o[1]), .busy_o(busy_o[1]), .done_o(done_o[1]), .err_o(err_o[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    function automatic string kname(int k);
        case (k)
            K_LOAD:  return "LOAD";
            K_KEY:   return "KEY";
            K_ARK:   return "ARK";
            K_SBGO:  return "SB_GO";
            K_SR:    return "SR";
            K_MC:    return "MC";
            K_DONE:  return "DONE";
            default: return "NONE";
        endcase
    endfunction

    task automatic chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_ev(int d, int k, int i, int t, int e);
        ev_t ev;
        ev.d = d; ev.kind = k; ev.idx = i; ev.t = t; ev.err = e;
        exp_q.push_back(ev);
    endtask

    // Expected event stream for one block: KEY lasts al cycles, SB_WAIT sl
    // cycles; stop early after event (cut_kind, cut_round) for abort/reset.
    task automatic expect_run(int d, int nr, int al, int sl, int hang, int tmo,
                              int cut_kind, int cut_round);
        int t;
        int r;
        t = 0;
        r = 0;
        push_ev(d, K_LOAD, 0, t, 0);
        t = 1;
        while (1) begin
            t = t + al - 1;
            push_ev(d, K_KEY, r, t, 0);
            t++;
            push_ev(d, K_ARK, r, t, 0);
            t++;
            if (r == nr) begin
                push_ev(d, K_DONE, r, t, 0);
                return;
            end
            r++;
            push_ev(d, K_SBGO, r, t, 0);
            if (cut_kind == K_SBGO && cut_round == r) return;
            t++;
            if (r == hang || sl > tmo) begin
                t = t + tmo;
                push_ev(d, K_DONE, r, t, 1);
                return;
            end
            t = t + sl;
            push_ev(d, K_SR, r, t, 0);
            t++;
            if (r < nr) begin
                push_ev(d, K_MC, r, t, 0);
                if (cut_kind == K_MC && cut_round == r) return;
                t++;
            end
        end
    endtask

    task automatic obs(int d, int k, int idx);
        ev_t e;
        int  t;
        t = cyc - t0[d];
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event dut%0d: got %s idx %0d t %0d, expected no event",
                     d, kname(k), idx, t);
        end else begin
            e = exp_q.pop_front();
            if (e.d != d || e.kind != k || e.idx != idx || e.t != t || e.err != int'(err_o[d])) begin
                n_err++;
                $display("FAIL event dut%0d: got %s idx %0d t %0d err %0d, expected dut%0d %s idx %0d t %0d err %0d",
                         d, kname(k), idx, t, int'(err_o[d]), e.d, kname(e.kind), e.idx, e.t, e.err);
            end
        end
    endtask

    task automatic monitor_dut(int d);
        if (load_o[d] === 1'b1) begin c_load[d]++; obs(d, K_LOAD, int'(round_o[d])); end
        if (rk_req_o[d] === 1'b1 && rk_ack_i[d] === 1'b1) obs(d, K_KEY, int'(rk_idx_o[d]));
        if (ark_en_o[d] === 1'b1) begin c_ark[d]++; obs(d, K_ARK, int'(round_o[d])); end
        if (sb_start_o[d] === 1'b1) begin c_sb[d]++; obs(d, K_SBGO, int'(round_o[d])); end
        if (sr_en_o[d] === 1'b1) begin c_sr[d]++; obs(d, K_SR, int'(round_o[d])); end
        if (mc_en_o[d] === 1'b1) begin c_mc[d]++; obs(d, K_MC, int'(round_o[d])); end
        if (done_o[d] === 1'b1) begin
            c_done[d]++;
            last_done_t[d] = cyc - t0[d];
            obs(d, K_DONE, int'(round_o[d]));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            for (int d = 0; d < 2; d++) monitor_dut(d);
        end
    end

    task automatic respond(int d);
        if (rk_req_o[d] === 1'b1) begin
            key_cnt[d]++;
            rk_ack_i[d] = (key_cnt[d] >= ack_lat[d]);
        end else begin
            key_cnt[d]  = 0;
            rk_ack_i[d] = ack_hold[d];
        end
        if (sb_start_o[d] === 1'b1) begin
            waiting[d]   = 1'b1;
            sb_cnt[d]    = 0;
            sb_done_i[d] = 1'b0;
        end else if (waiting[d] && busy_o[d] === 1'b1 && sr_en_o[d] !== 1'b1 && done_o[d] !== 1'b1) begin
            sb_cnt[d]++;
            sb_done_i[d] = (sb_cnt[d] >= sb_lat[d]) && (int'(round_o[d]) != hang_round[d]);
        end else begin
            waiting[d]   = 1'b0;
            sb_done_i[d] = 1'b0;
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rk_ack_i[d] = 1'b0;
            sb_done_i[d] = 1'b0;
            key_cnt[d] = 0;
            sb_cnt[d] = 0;
            waiting[d] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) respond(d);
        end
    end

    task automatic cfg(int d, int al, int sl, int hang, bit hold);
        ack_lat[d] = al; sb_lat[d] = sl; hang_round[d] = hang; ack_hold[d] = hold;
        c_load[d] = 0; c_ark[d] = 0; c_sb[d] = 0; c_sr[d] = 0; c_mc[d] = 0; c_done[d] = 0;
        last_done_t[d] = -1;
    endtask

    task automatic kick(int d, bit with_abort);
        @(negedge clk);
        start_i[d] = 1'b1;
        abort_i[d] = with_abort;
        if (!with_abort) t0[d] = cyc + 1;
        @(negedge clk);
        start_i[d] = 1'b0;
        abort_i[d] = 1'b0;
    endtask

    // what: 0 = done pulse, 1 = sb_start in round rnd, 2 = mc_en in round rnd.
    task automatic wait_for(int d, int what, int rnd, int limit, string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < limit && !hit; i++) begin
            @(negedge clk);
            case (what)
                0:       hit = (done_o[d] === 1'b1);
                1:       hit = (sb_start_o[d] === 1'b1) && (int'(round_o[d]) == rnd);
                default: hit = (mc_en_o[d] === 1'b1) && (int'(round_o[d]) == rnd);
            endcase
        end
        if (!hit) chk({name, "_reached"}, 0, 1);
    endtask

    task automatic settle(string name);
        repeat (3) @(negedge clk);
        chk({name, "_queue_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic chk_idle(int d, string name);
        chk({name, "_strobes"}, int'({load_o[d], rk_req_o[d], ark_en_o[d], sb_start_o[d],
                                      sr_en_o[d], mc_en_o[d], busy_o[d], done_o[d]}), 0);
        chk({name, "_round"}, int'(round_o[d]), 0);
        chk({name, "_err"}, int'(err_o[d]), 0);
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start_i[d] = 1'b0;
            abort_i[d] = 1'b0;
            t0[d] = 0;
            cfg(d, 1, 1, -1, 1'b1);
        end
        repeat (2) @(negedge clk);
        chk_idle(0, "reset0");
        chk_idle(1, "reset1");
        rst = 1'b0;

        // Baseline NR=10 block; a start pulse mid-run must be ignored.
        cfg(0, 1, 1, -1, 1'b1);
        expect_run(0, 10, 1, 1, -1, 255, K_NONE, 0);
        kick(0, 1'b0);
        repeat (5) @(negedge clk);
        start_i[0] = 1'b1;
        @(negedge clk);
        start_i[0] = 1'b0;
        wait_for(0, 0, 0, 200, "base_done");
        settle("base");
        chk("base_done_t", last_done_t[0], 62);
        chk("base_load", c_load[0], 1);
        chk("base_ark", c_ark[0], 11);
        chk("base_sb", c_sb[0], 10);
        chk("base_sr", c_sr[0], 10);
        chk("base_mc", c_mc[0], 9);
        chk("base_err", int'(err_o[0]), 0);

        // Slow key schedule (3 cycles) and slow sub_bytes (16 cycles).
        cfg(0, 3, 16, -1, 1'b0);
        expect_run(0, 10, 3, 16, -1, 255, K_NONE, 0);
        kick(0, 1'b0);
        wait_for(0, 0, 0, 400, "slow_done");
        settle("slow");
        chk("slow_done_t", last_done_t[0], 234);
        chk("slow_ark", c_ark[0], 11);

        // sub_bytes hangs in round 4: timeout after 255 wait cycles.
        cfg(0, 1, 1, 4, 1'b1);
        expect_run(0, 10, 1, 1, 4, 255, K_NONE, 0);
        kick(0, 1'b0);
        wait_for(0, 0, 0, 400, "tmo_done");
        settle("tmo");
        chk("tmo_done_t", last_done_t[0], 277);
        chk("tmo_done_cnt", c_done[0], 1);
        chk("tmo_sr", c_sr[0], 3);
        chk("tmo_busy", int'(busy_o[0]), 0);
        repeat (4) @(negedge clk);
        chk("tmo_err_sticky", int'(err_o[0]), 1);

        // start together with abort in IDLE is ignored; err stays set.
        kick(0, 1'b1);
        chk("start_abort_busy", int'(busy_o[0]), 0);
        chk("start_abort_err", int'(err_o[0]), 1);
        settle("start_abort");

        // Next accepted start clears err and completes normally.
        cfg(0, 1, 1, -1, 1'b1);
        expect_run(0, 10, 1, 1, -1, 255, K_NONE, 0);
        kick(0, 1'b0);
        chk("restart_err_clear", int'(err_o[0]), 0);
        wait_for(0, 0, 0, 200, "restart_done");
        settle("restart");
        chk("restart_done_t", last_done_t[0], 62);

        // Abort in the first SB_WAIT cycle of round 6.
        cfg(0, 1, 3, -1, 1'b1);
        expect_run(0, 10, 1, 3, -1, 255, K_SBGO, 6);
        kick(0, 1'b0);
        wait_for(0, 1, 6, 200, "abort_sbgo6");
        @(negedge clk);
        abort_i[0] = 1'b1;
        @(negedge clk);
        abort_i[0] = 1'b0;
        chk("abort_busy", int'(busy_o[0]), 0);
        chk("abort_round", int'(round_o[0]), 6);
        chk("abort_err", int'(err_o[0]), 0);
        settle("abort");
        chk("abort_no_done", c_done[0], 0);

        cfg(0, 1, 1, -1, 1'b1);
        expect_run(0, 10, 1, 1, -1, 255, K_NONE, 0);
        kick(0, 1'b0);
        wait_for(0, 0, 0, 200, "post_abort_done");
        settle("post_abort");
        chk("post_abort_done_t", last_done_t[0], 62);
        chk("post_abort_mc", c_mc[0], 9);

        // Reset during MC of round 3.
        cfg(0, 1, 1, -1, 1'b1);
        expect_run(0, 10, 1, 1, -1, 255, K_MC, 3);
        kick(0, 1'b0);
        wait_for(0, 2, 3, 200, "rst_mc3");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle(0, "rst_mc3");
        settle("rst_mc3");

        // NR=1 single-round block: no MixColumns.
        cfg(1, 1, 1, -1, 1'b1);
        expect_run(1, 1, 1, 1, -1, 3, K_NONE, 0);
        kick(1, 1'b0);
        wait_for(1, 0, 0, 50, "nr1_done");
        settle("nr1");
        chk("nr1_done_t", last_done_t[1], 8);
        chk("nr1_ark", c_ark[1], 2);
        chk("nr1_sr", c_sr[1], 1);
        chk("nr1_mc", c_mc[1], 0);

        // sb_done on the TIMEOUT-th (3rd) wait cycle wins.
        cfg(1, 1, 3, -1, 1'b1);
        expect_run(1, 1, 1, 3, -1, 3, K_NONE, 0);
        kick(1, 1'b0);
        wait_for(1, 0, 0, 50, "edge_done");
        settle("edge");
        chk("edge_done_t", last_done_t[1], 10);
        chk("edge_err", int'(err_o[1]), 0);

        // One cycle late: timeout after 3 wait cycles, then reset clears err.
        cfg(1, 1, 4, -1, 1'b1);
        expect_run(1, 1, 1, 4, -1, 3, K_NONE, 0);
        kick(1, 1'b0);
        wait_for(1, 0, 0, 50, "late_done");
        settle("late");
        chk("late_done_t", last_done_t[1], 7);
        chk("late_err", int'(err_o[1]), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("late_rst_err", int'(err_o[1]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
